// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, holds the
// returned instruction for decode, applies branch-unit redirects. Optional PC_MISALIGN_CHK_EN.
module pc_fetch_ctrl #(
    parameter int             AW       = 32,
    parameter int             DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          if_ready,
    input  logic          redirect_valid,
`ifdef PC_MISALIGN_CHK_EN
    input  logic [AW-1:0] redirect_pc,
    output logic          misalign_valid,
    output logic [AW-1:0] misalign_addr
`else
    input  logic [AW-1:0] redirect_pc
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, HOLD} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          if_valid_q, if_valid_d;
    logic [DW-1:0] if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;

    logic          redir_ok;
    logic          redir_bad;
    logic [AW-1:0] redir_tgt;
    logic [AW-1:0] pc_plus4;

`ifdef PC_MISALIGN_CHK_EN
    logic          misalign_valid_q, misalign_valid_d;
    logic [AW-1:0] misalign_addr_q, misalign_addr_d;

    // A misaligned target is reported instead of being applied.
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_ok  = redirect_valid && !redir_bad;
    assign redir_tgt = redirect_pc;

    always_comb begin
        misalign_valid_d = redir_bad;
        misalign_addr_d  = redir_bad ? redirect_pc : misalign_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_valid_q <= 1'b0;
            misalign_addr_q  <= '0;
        end else begin
            misalign_valid_q <= misalign_valid_d;
            misalign_addr_q  <= misalign_addr_d;
        end
    end

    assign misalign_valid = misalign_valid_q;
    assign misalign_addr  = misalign_addr_q;
`else
    assign redir_bad = 1'b0;
    assign redir_ok  = redirect_valid;
    assign redir_tgt = redirect_pc & {{(AW-2){1'b1}}, 2'b00};
`endif

    assign pc_plus4 = pc_q + {{(AW-3){1'b0}}, 3'b100};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redir_ok) pc_d = redir_tgt;
                // A grant in the same cycle as a redirect fetched the old PC.
                if (imem_gnt) state_d = redir_ok ? DISCARD : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redir_ok) begin
                        pc_d    = redir_tgt;
                        state_d = REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redir_ok) begin
                    pc_d    = redir_tgt;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (redir_ok)    pc_d    = redir_tgt;
                if (imem_rvalid) state_d = REQ;
            end
            HOLD: begin
                if (redir_ok) begin
                    pc_d       = redir_tgt;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end else if (redir_bad || if_ready) begin
                    if (!redir_bad) pc_d = pc_plus4;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized + directed bench for pc_fetch_ctrl against a transaction-level model.
module tb_pc_fetch_ctrl;

`ifdef PC_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef PC_MISALIGN_CHK_EN
    logic        misalign_valid;
    logic [31:0] misalign_addr;
`endif

    int errs = 0;
    int checks = 0;

    pc_fetch_ctrl #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .redirect_valid(redirect_valid),
`ifdef PC_MISALIGN_CHK_EN
        .redirect_pc(redirect_pc),
        .misalign_valid(misalign_valid), .misalign_addr(misalign_addr)
`else
        .redirect_pc(redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: booleans for "starting up", "requesting", "transaction in flight"
    // (and whether its data is already stale), and "instruction held".
    bit          m_start, m_req, m_out, m_stale, m_hv, m_mv;
    logic [31:0] m_pc, m_instr, m_ipc, m_maddr;
    bit          t_bad, t_go;
    logic [31:0] t_tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_start = 1; m_req = 0; m_out = 0; m_stale = 0; m_hv = 0; m_mv = 0;
            m_pc = 0; m_instr = 0; m_ipc = 0; m_maddr = 0;
        end else begin
            t_bad = MIS_EN && redirect_valid && (redirect_pc[1:0] != 2'b00);
            t_go  = redirect_valid && !t_bad;
            t_tgt = MIS_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
            m_mv = t_bad;
            if (t_bad) m_maddr = redirect_pc;
            if (m_start) begin
                m_start = 0; m_req = 1;
            end else if (m_req) begin
                if (t_go) m_pc = t_tgt;
                if (imem_gnt) begin m_req = 0; m_out = 1; m_stale = t_go; end
            end else if (m_out) begin
                if (imem_rvalid) begin
                    m_out = 0;
                    if (t_go) m_pc = t_tgt;
                    if (m_stale || t_go) m_req = 1;
                    else begin m_hv = 1; m_instr = imem_rdata; m_ipc = m_pc; end
                end else if (t_go) begin
                    m_pc = t_tgt; m_stale = 1;
                end
            end else if (m_hv) begin
                if (t_go)            begin m_pc = t_tgt;  m_hv = 0; m_req = 1; end
                else if (t_bad)      begin                m_hv = 0; m_req = 1; end
                else if (if_ready)   begin m_pc = m_pc+4; m_hv = 0; m_req = 1; end
            end
        end
    end

    // Single compare process against the model, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("imem_req",  {31'b0, imem_req}, {31'b0, m_req});
            check("imem_addr", imem_addr, m_pc);
            check("if_valid",  {31'b0, if_valid}, {31'b0, m_hv});
            check("if_instr",  if_instr, m_instr);
            check("if_pc",     if_pc, m_ipc);
`ifdef PC_MISALIGN_CHK_EN
            check("misalign_valid", {31'b0, misalign_valid}, {31'b0, m_mv});
            check("misalign_addr",  misalign_addr, m_maddr);
`endif
        end
    end

    task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                         input bit rdy, input bit rdir, input logic [31:0] rpc);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        if_ready = rdy; redirect_valid = rdir; redirect_pc = rpc;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit lit);
        #2 rst_n = 1'b0;
        #1;
        if (lit) begin
            check("rst_imem_req",  {31'b0, imem_req}, 32'h0);
            check("rst_imem_addr", imem_addr, 32'h0);
            check("rst_if_valid",  {31'b0, if_valid}, 32'h0);
            check("rst_if_instr",  if_instr, 32'h0);
            check("rst_if_pc",     if_pc, 32'h0);
        end
        imem_gnt = 0; imem_rvalid = 0; if_ready = 0; redirect_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit g, rv, rdy, rdir;
        logic [31:0] rpc;
        repeat (3) @(negedge clk);
        check("por_if_valid", {31'b0, if_valid}, 32'h0);
        check("por_imem_req", {31'b0, imem_req}, 32'h0);
        rst_n = 1'b1;

        // Back-to-back sequential fetch.
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("seq_req",  {31'b0, imem_req}, 32'h1);
            check("seq_addr", imem_addr, 32'(4 * i));
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 1, 32'h13, 0, 0, 0);
            check("seq_valid", {31'b0, if_valid}, 32'h1);
            check("seq_pc",    if_pc, 32'(4 * i));
            check("seq_instr", if_instr, 32'h13);
            if (i < 2) drive(0, 0, 0, 1, 0, 0);
        end

        // Redirect while holding.
        drive(0, 0, 0, 1, 1, 32'h100);
        check("hold_redir_addr",  imem_addr, 32'h100);
        check("hold_redir_valid", {31'b0, if_valid}, 32'h0);

        // Redirect while waiting -> late data discarded.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check("disc_addr",  imem_addr, 32'h200);
        check("disc_valid", {31'b0, if_valid}, 32'h0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h1111, 0, 0, 0);
        check("disc_pc",    if_pc, 32'h200);
        check("disc_instr", if_instr, 32'h1111);

        // Redirect while request not yet granted.
        drive(0, 0, 0, 1, 0, 0);
        check("ngnt_addr0", imem_addr, 32'h204);
        drive(0, 0, 0, 0, 1, 32'h40);
        check("ngnt_addr1", imem_addr, 32'h40);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h4040, 0, 0, 0);
        check("ngnt_pc",    if_pc, 32'h40);
        check("ngnt_instr", if_instr, 32'h4040);

        // PC wrap.
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h5, 0, 0, 0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 0, 0);
        check("wrap_addr1", imem_addr, 32'h0);

        // Reset while waiting, then a stray rvalid.
        drive(1, 0, 0, 0, 0, 0);
        do_reset(1'b1);
        drive(0, 1, 32'h777, 0, 0, 0);
        check("stray_req",   {31'b0, imem_req}, 32'h1);
        drive(0, 1, 32'h778, 0, 0, 0);
        check("stray_valid", {31'b0, if_valid}, 32'h0);

        // Misaligned redirect.
        drive(0, 0, 0, 0, 1, 32'h102);
`ifdef PC_MISALIGN_CHK_EN
        check("mis_addr_unch", imem_addr, 32'h0);
        check("mis_valid",     {31'b0, misalign_valid}, 32'h1);
        check("mis_maddr",     misalign_addr, 32'h102);
        drive(0, 0, 0, 0, 0, 0);
        check("mis_pulse",     {31'b0, misalign_valid}, 32'h0);
`else
        check("mis_forced", imem_addr, 32'h100);
`endif

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset(1'b0);
            g   = ($urandom_range(0, 2) != 0);
            rv  = m_out ? bit'($urandom_range(0, 1))
                        : ((m_start || m_req) ? ($urandom_range(0, 7) == 0) : 1'b0);
            rdy = bit'($urandom_range(0, 1));
            rdir = ($urandom_range(0, 4) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFFC;
            drive(g, rv, $urandom, rdy, rdir, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer for the multi-cycle core variant.
- Owns the architectural PC and issues one instruction-memory request at a time.
- Holds each returned instruction for the decode/execute stage until it is consumed.
- Applies control-flow redirects from the branch unit (its taken/jump select plus computed target), dropping in-flight or held instructions as required.

Parameters:
- AW, 32, address/PC width
- DW, 32, instruction data width
- RESET_PC, 32'h0000_0000, PC loaded on reset (AW bits)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  AW  fetch address (= PC)
- imem_gnt  input  1  memory accepted request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  DW  read data
- if_valid  output  1  held instruction valid
- if_instr  output  DW  held instruction
- if_pc  output  AW  PC of held instruction
- if_ready  input  1  downstream consumes held instruction
- redirect_valid  input  1  branch unit: take target (taken branch, jal, jalr)
- redirect_pc  input  AW  redirect target

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- Reset mid-operation aborts everything immediately. Any rvalid arriving in IDLE or REQ is ignored.
- States: IDLE, REQ, WAIT, DISCARD, HOLD.
- All outputs are registered or decoded from state/registers. No combinational path from inputs to outputs.
- IDLE: next cycle -> REQ.
- REQ: imem_req=1, imem_addr=pc.
  - gnt & !redirect -> WAIT.
  - gnt & redirect -> pc<=redirect_pc, DISCARD (granted fetch is stale).
  - !gnt & redirect -> pc<=redirect_pc, stay REQ. Address changes next cycle; memory samples imem_addr only on gnt.
- WAIT: imem_req=0.
  - rvalid & !redirect -> latch if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, -> HOLD.
  - rvalid & redirect -> drop data, pc<=redirect_pc, -> REQ.
  - !rvalid & redirect -> pc<=redirect_pc, -> DISCARD.
- DISCARD: imem_req=0, if_valid=0.
  - rvalid -> drop data, -> REQ.
  - redirect while waiting -> pc<=redirect_pc (latest wins), stay.
  - rvalid & redirect same cycle -> pc<=redirect_pc, -> REQ.
- HOLD: if_valid=1, outputs stable while if_ready=0.
  - redirect (with or without if_ready) -> pc<=redirect_pc, if_valid<=0, -> REQ.
  - if_ready & !redirect -> pc<=pc+4, if_valid<=0, -> REQ.
- Redirect always has priority over sequential increment.
- PC arithmetic: pc+4 modulo 2^AW (0xFFFF_FFFC wraps to 0x0000_0000).
- Minimum latency with gnt in REQ and rvalid the next cycle: REQ->WAIT->HOLD, if_valid 2 cycles after the first imem_req cycle.
- Maximum throughput: one instruction per 3 cycles.
- Exactly one outstanding memory transaction at any time. Every granted request's response is either delivered or discarded, never both.
- if_valid never asserts for an instruction fetched from an address superseded by a redirect.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined: adds ports misalign_valid (output, 1) and misalign_addr (output, AW), both reset to 0.
  - A redirect with redirect_pc[1:0]!=0 is not applied: pc unchanged, no state transition caused by the redirect.
  - misalign_valid pulses high for one cycle the cycle after; misalign_addr<=redirect_pc.
  - The held instruction in HOLD is also dropped (if_valid<=0, -> REQ at the unchanged pc).
- Not defined: ports absent. redirect_pc[1:0] is forced to 2'b00 when loaded into pc.

Test Plan:
- Reset release, gnt=1 immediately, rvalid the next cycle, rdata=0x00000013, if_ready=1 on every HOLD -> fetch addresses 0x0,0x4,0x8; if_valid every 3rd cycle with if_pc=0x0,0x4,0x8.
- In HOLD (if_pc=0x8), redirect_valid=1 with redirect_pc=0x100 and if_ready=1 -> next imem_addr=0x100; the held instruction is not re-presented.
- In WAIT, redirect to 0x200 with rvalid delayed 3 cycles -> DISCARD. The late rdata is never seen on if_instr; the next request addr is 0x200 and the first if_pc is 0x200.
- In REQ with gnt=0 for 4 cycles, redirect to 0x40 in cycle 2 -> imem_addr changes 0x0->0x40. On gnt, the returned data is delivered with if_pc=0x40.
- pc=0xFFFFFFFC, consumed with if_ready=1 -> next imem_addr=0x00000000. rst_n asserted during WAIT -> all outputs at reset values immediately; a stray rvalid after reset is ignored.
- With PC_MISALIGN_CHK_EN: redirect to 0x102 -> misalign_valid=1 for one cycle, misalign_addr=0x102, imem_addr unchanged. Without it: the same redirect fetches 0x100.
